// File: rtl/colour_message_tx_if.sv
// Handshake bundle between the navigation logic, the colour sensor and the
// colour report transmitter.
interface colour_message_tx_if;
  logic       trigger;
  logic [4:0] node_id;
  logic       valid;
  logic [2:0] color;
  logic       measure;
  logic       tx;
  logic       busy;
  logic       msg_done;
  logic [2:0] last_color;

  modport master (
    output trigger, node_id, valid, color,
    input  measure, tx, busy, msg_done, last_color
  );

  modport slave (
    input  trigger, node_id, valid, color,
    output measure, tx, busy, msg_done, last_color
  );
endinterface

// File: rtl/colour_message_tx.sv
// Requests one colour measurement, then sends "C<col>-<tens><ones>#" as six
// 8N1 UART bytes. Every output comes straight from a register.
module colour_message_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               reset,
  colour_message_tx_if.slave bus
);
  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAITV, LOAD, START, DATA, STOP, NEXT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    last_color_q, last_color_d;
  logic          measure_q, measure_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [4:0]    node_q, node_d;

  logic [1:0]    tens;
  logic [4:0]    tens_x10;
  logic [3:0]    ones;
  logic [7:0]    byte_sel;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Node number split into decimal digits by threshold compare.
  always_comb begin
    tens     = 2'd0;
    tens_x10 = 5'd0;
    if (node_q >= 5'd30) begin
      tens     = 2'd3;
      tens_x10 = 5'd30;
    end else if (node_q >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = 5'd20;
    end else if (node_q >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = 5'd10;
    end
    ones = 4'(node_q - tens_x10);
  end

  always_comb begin
    case (idx_q)
      3'd0: byte_sel = 8'h43;
      3'd1: begin
        case (last_color_q)
          3'b001:  byte_sel = 8'h52;
          3'b010:  byte_sel = 8'h47;
          3'b011:  byte_sel = 8'h42;
          default: byte_sel = 8'h4E;
        endcase
      end
      3'd2:    byte_sel = 8'h2D;
      3'd3:    byte_sel = {6'b001100, tens};
      3'd4:    byte_sel = {4'h3, ones};
      default: byte_sel = 8'h23;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    last_color_d = last_color_q;
    measure_d    = measure_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    shreg_d      = shreg_q;
    node_d       = node_q;

    case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          node_d    = bus.node_id;
          busy_d    = 1'b1;
          measure_d = 1'b1;
          idx_d     = 3'd0;
          state_d   = REQ;
        end
      end
      // measure stays up until the sensor has visibly dropped its old result
      REQ: begin
        if (!bus.valid) begin
          measure_d = 1'b0;
          state_d   = WAITV;
        end
      end
      WAITV: begin
        if (bus.valid) begin
          last_color_d = bus.color;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        shreg_d = byte_sel;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = NEXT;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q < 3'd5) begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end else begin
          idx_d   = 3'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      idx_q        <= 3'd0;
      last_color_q <= 3'b000;
      measure_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      last_color_q <= last_color_d;
      measure_q    <= measure_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Payload registers are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    node_q  <= node_d;
  end

  assign bus.measure    = measure_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.msg_done   = done_q;
  assign bus.last_color = last_color_q;
endmodule

// File: tb/tb_colour_message_tx.sv
// Directed bench for colour_message_tx: expected UART bytes are queued when a
// trigger is issued and a UART decoder process pops and compares them.
module tb_colour_message_tx;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  colour_message_tx_if ifc ();

  colour_message_tx #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [47:0] bytes);
    for (int i = 5; i >= 0; i--) exp_q.push_back(bytes[i*8 +: 8]);
  endtask

  // Drive trigger for one sampling edge; returns on the negedge after acceptance.
  task automatic issue(input logic [4:0] node, input logic [47:0] bytes,
                       input bit push, input bit hold);
    if (push) push_msg(bytes);
    ifc.node_id = node;
    ifc.trigger = 1'b1;
    @(negedge clk);
    if (!hold) ifc.trigger = 1'b0;
  endtask

  // Sensor behaviour plus end-of-message checks, starting at the first negedge with measure high.
  task automatic complete(input bit vinit, input logic [2:0] col,
                          input logic [2:0] junk_col, input string tag);
    int mh;
    int ext;
    int d;
    int t0;
    mh = 0;
    for (int i = 0; i < 64 && ifc.measure; i++) begin
      mh++;
      if (vinit && mh == 4) ifc.valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, " measure-high-cycles"}, mh, vinit ? 4 : 1);
    ifc.valid = 1'b0;
    ifc.color = junk_col;
    ext = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.measure) ext++;
    end
    ifc.valid = 1'b1;
    ifc.color = col;
    d = 0;
    while (ifc.tx !== 1'b0 && d < 64) begin
      @(negedge clk);
      d++;
      if (ifc.measure) ext++;
    end
    chk({tag, " valid-to-start-bit"}, d, 2);
    ifc.color = junk_col;
    t0 = cyc;
    d = 0;
    while (ifc.msg_done !== 1'b1 && d < 2000) begin
      @(negedge clk);
      d++;
      if (ifc.measure) ext++;
    end
    chk({tag, " frame-length"}, cyc - t0, 251);
    chk({tag, " extra-measure"}, ext, 0);
    chk({tag, " busy-at-done"}, ifc.busy, 0);
    chk({tag, " last_color"}, ifc.last_color, col);
    @(negedge clk);
    chk({tag, " msg_done-width"}, ifc.msg_done, 0);
  endtask

  // UART decoder: samples every cycle of each bit so wrong bit lengths break framing.
  initial begin : uart_mon
    logic [7:0] b;
    logic       v;
    logic       ref_v;
    logic [7:0] e;
    bit         ok;
    bit         ab;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && ifc.tx === 1'b0) begin
        ok = 1'b1;
        ab = 1'b0;
        b = '0;
        ref_v = 1'b0;
        for (int slot = 0; slot < 10 && !ab; slot++) begin
          for (int s = 0; s < 4 && !ab; s++) begin
            if (slot != 0 || s != 0) @(negedge clk);
            if (reset !== 1'b0) ab = 1'b1;
            else begin
              v = ifc.tx;
              if (s == 0) ref_v = v;
              else if (v !== ref_v) ok = 1'b0;
            end
          end
          if (!ab) begin
            if (slot == 0 && ref_v !== 1'b0) ok = 1'b0;
            if (slot == 9 && ref_v !== 1'b1) ok = 1'b0;
            if (slot >= 1 && slot <= 8) b[slot-1] = ref_v;
          end
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected-byte: got %0h, expected none", b);
          end else begin
            e = exp_q.pop_front();
            chk("uart-byte", b, e);
            chk("uart-framing", ok, 1);
          end
        end
      end
    end
  end

  initial begin
    int d;
    ifc.trigger = 1'b0;
    ifc.node_id = 5'd0;
    ifc.valid   = 1'b1;
    ifc.color   = 3'b010;
    reset       = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("por tx", ifc.tx, 1);
    chk("por measure", ifc.measure, 0);
    chk("por busy", ifc.busy, 0);
    chk("por msg_done", ifc.msg_done, 0);
    chk("por last_color", ifc.last_color, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Red, node 7, stale green result present at trigger
    issue(5'd7, 48'h43522D303723, 1'b1, 1'b0);
    complete(1'b1, 3'b001, 3'b110, "red7");

    // Blue, node 31
    issue(5'd31, 48'h43422D333123, 1'b1, 1'b0);
    complete(1'b1, 3'b011, 3'b000, "blue31");

    // Illegal colour code, node 10
    issue(5'd10, 48'h434E2D313023, 1'b1, 1'b0);
    complete(1'b1, 3'b101, 3'b011, "bad10");

    // Sensor already mid-measurement, green, node 0
    ifc.valid = 1'b0;
    ifc.color = 3'b001;
    issue(5'd0, 48'h43472D303023, 1'b1, 1'b0);
    complete(1'b0, 3'b010, 3'b011, "mid0");

    // Asynchronous reset while measure is held
    issue(5'd3, 48'h0, 1'b0, 1'b0);
    chk("rstreq measure-before", ifc.measure, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstreq measure", ifc.measure, 0);
    chk("rstreq busy", ifc.busy, 0);
    chk("rstreq last_color", ifc.last_color, 0);
    chk("rstreq tx", ifc.tx, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Asynchronous reset during a start bit
    ifc.valid = 1'b0;
    issue(5'd4, 48'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    ifc.valid = 1'b1;
    ifc.color = 3'b001;
    d = 0;
    while (ifc.tx !== 1'b0 && d < 64) begin
      @(negedge clk);
      d++;
    end
    chk("rstframe tx-low-before", ifc.tx, 0);
    chk("rstframe last_color-before", ifc.last_color, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstframe tx", ifc.tx, 1);
    chk("rstframe busy", ifc.busy, 0);
    chk("rstframe measure", ifc.measure, 0);
    chk("rstframe last_color", ifc.last_color, 0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Back-to-back: trigger held through the first message
    issue(5'd12, 48'h43422D313223, 1'b1, 1'b1);
    ifc.node_id = 5'd25;
    complete(1'b1, 3'b011, 3'b001, "b2b1");
    chk("b2b busy-relaunch", ifc.busy, 1);
    chk("b2b measure-relaunch", ifc.measure, 1);
    ifc.trigger = 1'b0;
    push_msg(48'h43522D323523);
    complete(1'b1, 3'b001, 3'b000, "b2b2");

    repeat (20) @(negedge clk);
    chk("leftover-expected-bytes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
